// File: rtl/pkt_parser_pkg.sv
// Shared definitions for the packet-parser front end: header sizes,
// the strip FSM state type and the byte realignment helper.
package pkt_parser_pkg;

  localparam int          ETH_HDR_BYTES  = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          BYTES_PER_BEAT = 64;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DROP
  } eth_strip_state_t;

  // Builds one output beat from the tail of the held beat and the head of
  // the next beat. The result is hold bytes 14..63 followed by data
  // bytes 0..13, with byte 0 sitting in the top bits.
  function automatic logic [511:0] realign(input logic [511:0] hold,
                                           input logic [511:0] data);
    return {hold[(BYTES_PER_BEAT-ETH_HDR_BYTES)*8-1:0],
            data[511 -: ETH_HDR_BYTES*8]};
  endfunction

endpackage

// File: rtl/eth_strip_512.sv
// Ethernet header strip and steer stage. It drops non-IPv4 frames and runt
// frames, removes the 14-byte MAC header, realigns the payload so the IPv4
// header starts on byte 0, and picks the destination parser port round-robin
// for each packet it forwards.
module eth_strip_512
  import pkt_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_RADIX  = 16,
  parameter int NUM_VC     = 2,
  parameter int VC_ID      = 0,
  parameter int NUM_DST    = 4,
  parameter logic [$clog2(NOC_RADIX)-1:0] DEST [NUM_DST] = '{4'd4, 4'd5, 4'd6, 4'd7}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [5:0]                    in_empty,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [5:0]                    out_empty,
  output logic [$clog2(NUM_VC)-1:0]     o_vc_id,
  output logic [$clog2(NOC_RADIX)-1:0]  o_noc_dst,
  output logic [15:0]                   o_drop_cnt
);

  localparam int         VC_W     = $clog2(NUM_VC);
  localparam int         PTR_W    = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DST - 1);
  // Input empties at or above this leave a tail that fits in the current
  // output beat, so no extra flush cycle is needed.
  localparam logic [5:0] TAIL_FIT = 6'(BYTES_PER_BEAT - ETH_HDR_BYTES);

  eth_strip_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [15:0]             dropCnt_q, dropCnt_d;
  logic [5:0]              lastEmpty_q, lastEmpty_d;
  logic                    sopPend_q, sopPend_d;
  logic                    advancePtr;
  logic                    countDrop;
  logic [15:0]             etherType;
  logic                    isRunt;

  assign etherType = in_data[DATA_WIDTH-1-(ETH_HDR_BYTES-2)*8 -: 16];
  assign isRunt    = in_eop && (in_empty >= TAIL_FIT);

  assign o_vc_id    = VC_W'(VC_ID);
  assign o_noc_dst  = DEST[ptr_q];
  assign o_drop_cnt = dropCnt_q;

  // Next-state and output decode for the strip FSM; outputs are combinational
  // from the held beat and the current input beat.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    lastEmpty_d = lastEmpty_q;
    sopPend_d   = sopPend_q;
    advancePtr  = 1'b0;
    countDrop   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = realign(hold_q, in_data);
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    out_empty   = 6'd0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_sop) begin
          if ((etherType != ETHERTYPE_IPV4) || isRunt) begin
            countDrop = 1'b1;
            if (!in_eop) begin
              state_d = DROP;
            end
          end else begin
            hold_d      = in_data;
            sopPend_d   = 1'b1;
            lastEmpty_d = in_empty;
            state_d     = in_eop ? FLUSH : STREAM;
          end
        end
      end

      STREAM: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_sop   = sopPend_q;
        if (in_eop && (in_empty >= TAIL_FIT)) begin
          out_eop   = 1'b1;
          out_empty = in_empty - TAIL_FIT;
        end
        if (in_valid && out_ready) begin
          hold_d    = in_data;
          sopPend_d = 1'b0;
          if (in_eop) begin
            if (in_empty >= TAIL_FIT) begin
              state_d    = IDLE;
              advancePtr = 1'b1;
            end else begin
              lastEmpty_d = in_empty;
              state_d     = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        out_valid = 1'b1;
        out_data  = realign(hold_q, '0);
        out_sop   = sopPend_q;
        out_eop   = 1'b1;
        out_empty = 6'(ETH_HDR_BYTES) + lastEmpty_q;
        if (out_ready) begin
          sopPend_d  = 1'b0;
          advancePtr = 1'b1;
          state_d    = IDLE;
        end
      end

      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Round-robin destination pointer and saturating drop counter updates.
  always_comb begin
    ptr_d     = ptr_q;
    dropCnt_d = dropCnt_q;
    if (advancePtr) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
    if (countDrop && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  // State registers; reset discards any partial packet and restarts at port 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      ptr_q       <= '0;
      dropCnt_q   <= 16'd0;
      lastEmpty_q <= 6'd0;
      sopPend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      dropCnt_q   <= dropCnt_d;
      lastEmpty_q <= lastEmpty_d;
      sopPend_q   <= sopPend_d;
    end
  end

endmodule

// File: tb/tb_eth_strip_512.sv
// Directed testbench for eth_strip_512: frames are built as byte arrays,
// driven beat by beat, and every output beat is compared with the frame
// minus its first 14 bytes.
module tb_eth_strip_512;

  logic         clk;
  logic         rstN;
  logic [511:0] inData;
  logic         inValid;
  logic         inReady;
  logic         inSop;
  logic         inEop;
  logic [5:0]   inEmpty;
  logic [511:0] outData;
  logic         outValid;
  logic         outReady;
  logic         outSop;
  logic         outEop;
  logic [5:0]   outEmpty;
  logic [0:0]   vcId;
  logic [3:0]   nocDst;
  logic [15:0]  dropCnt;

  int checks = 0;
  int errors = 0;
  int expPtr = 0;
  int expDrop = 0;

  logic [3:0] destTab [4] = '{4'd4, 4'd5, 4'd6, 4'd7};

  logic [7:0] frameB [0:511];
  int         frameLen;

  eth_strip_512 dut (
    .clk        (clk),
    .reset      (rstN),
    .in_data    (inData),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_sop     (inSop),
    .in_eop     (inEop),
    .in_empty   (inEmpty),
    .out_data   (outData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_sop    (outSop),
    .out_eop    (outEop),
    .out_empty  (outEmpty),
    .o_vc_id    (vcId),
    .o_noc_dst  (nocDst),
    .o_drop_cnt (dropCnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Fills the frame buffer with a seeded byte pattern and the given EtherType.
  task automatic fillFrame(input int len, input logic [15:0] etype, input int seed);
    frameLen = len;
    for (int i = 0; i < 512; i++) begin
      frameB[i] = (i < len) ? 8'((i * 7 + seed) & 255) : 8'h00;
    end
    frameB[12] = etype[15:8];
    frameB[13] = etype[7:0];
  endtask

  // Input beat b of the current frame; bytes past the frame end are zero.
  function automatic logic [511:0] inBeat(input int b);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 64; j++) begin
      if (b * 64 + j < frameLen) v[511 - 8*j -: 8] = frameB[b * 64 + j];
    end
    return v;
  endfunction

  // Expected output beat k: frame bytes from 14 onward, zero past the end.
  function automatic logic [511:0] expBeat(input int k);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 64; j++) begin
      if (14 + k * 64 + j < frameLen) v[511 - 8*j -: 8] = frameB[14 + k * 64 + j];
    end
    return v;
  endfunction

  // Drives the current frame and checks every output beat against the model.
  task automatic applyStimulus(input string tag, input int len, input logic [15:0] etype,
                               input int seed, input bit randReady);
    int nIn, nOut, inIdx, outK, cycles;
    bit isDrop, stalledPrev;
    logic [511:0] prevData;
    fillFrame(len, etype, seed);
    isDrop = (etype != 16'h0800) || (len <= 14);
    nIn = (len + 63) / 64;
    nOut = isDrop ? 0 : (len - 14 + 63) / 64;
    inIdx = 0;
    outK = 0;
    cycles = 0;
    stalledPrev = 1'b0;
    prevData = '0;
    while ((inIdx < nIn || outK < nOut) && cycles < 400) begin
      @(negedge clk);
      inValid  = (inIdx < nIn);
      inData   = (inIdx < nIn) ? inBeat(inIdx) : '0;
      inSop    = (inIdx == 0);
      inEop    = (inIdx == nIn - 1);
      inEmpty  = (inIdx == nIn - 1) ? 6'(nIn * 64 - len) : 6'd0;
      outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalledPrev) begin
        checkOutput({tag, " stallValid"}, outValid, 1);
        checkOutput({tag, " stallData"}, outData, prevData);
      end
      if (outValid && outReady) begin
        if (outK >= nOut) begin
          checkOutput({tag, " beatCount"}, outK + 1, nOut);
        end else begin
          checkOutput({tag, " data"}, outData, expBeat(outK));
          checkOutput({tag, " sop"}, outSop, (outK == 0));
          checkOutput({tag, " eop"}, outEop, (outK == nOut - 1));
          checkOutput({tag, " nocDst"}, nocDst, destTab[expPtr]);
          if (outK == nOut - 1) begin
            checkOutput({tag, " empty"}, outEmpty, nOut * 64 - (len - 14));
          end
        end
        outK++;
      end
      stalledPrev = outValid && !outReady;
      prevData = outData;
      if (inValid && inReady) inIdx++;
      cycles++;
    end
    checkOutput({tag, " done"}, (inIdx == nIn && outK == nOut), 1);
    @(negedge clk);
    inValid  = 1'b0;
    inSop    = 1'b0;
    inEop    = 1'b0;
    outReady = 1'b1;
    #1;
    if (isDrop) expDrop++;
    else expPtr = (expPtr + 1) % 4;
    checkOutput({tag, " idleValid"}, outValid, 0);
    checkOutput({tag, " dropCnt"}, dropCnt, expDrop);
    checkOutput({tag, " nextDst"}, nocDst, destTab[expPtr]);
  endtask

  // Pulses reset for two cycles and checks the reset state while held.
  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    inValid = 1'b0;
    #1;
    expPtr = 0;
    expDrop = 0;
    checkOutput("rst outValid", outValid, 0);
    checkOutput("rst inReady", inReady, 1);
    checkOutput("rst nocDst", nocDst, 4);
    checkOutput("rst dropCnt", dropCnt, 0);
    checkOutput("rst vcId", vcId, 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN     = 1'b0;
    inData   = '0;
    inValid  = 1'b0;
    inSop    = 1'b0;
    inEop    = 1'b0;
    inEmpty  = 6'd0;
    outReady = 1'b1;

    doReset();

    // Non-IPv4 frame is dropped and counted, next IPv4 frame goes to port 0.
    applyStimulus("v6drop", 180, 16'h86DD, 3, 1'b0);
    applyStimulus("afterDrop", 100, 16'h0800, 5, 1'b0);
    // Runt: sop&eop with empty 52 leaves only 12 bytes.
    applyStimulus("runt", 12, 16'h0800, 9, 1'b0);

    // A beat without sop in IDLE is discarded silently.
    @(negedge clk);
    inValid = 1'b1;
    inSop   = 1'b0;
    inEop   = 1'b1;
    inData  = {64{8'hA5}};
    #1;
    checkOutput("noSop outValid", outValid, 0);
    checkOutput("noSop inReady", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    inEop   = 1'b0;
    #1;
    checkOutput("noSop dropCnt", dropCnt, expDrop);
    checkOutput("noSop outValid2", outValid, 0);

    doReset();

    // Five back-to-back frames: destinations 4,5,6,7,4.
    applyStimulus("single64", 64, 16'h0800, 1, 1'b0);
    applyStimulus("twoBeat128", 128, 16'h0800, 2, 1'b0);
    applyStimulus("short73", 73, 16'h0800, 4, 1'b0);
    applyStimulus("b2b150", 150, 16'h0800, 6, 1'b0);
    applyStimulus("b2b90", 90, 16'h0800, 8, 1'b0);

    // Random backpressure during 4-beat frames.
    applyStimulus("stall230", 230, 16'h0800, 11, 1'b1);
    applyStimulus("stall250", 250, 16'h0800, 13, 1'b1);

    // Reset in the middle of a streaming packet.
    fillFrame(200, 16'h0800, 17);
    @(negedge clk);
    inValid = 1'b1;
    inSop   = 1'b1;
    inEop   = 1'b0;
    inEmpty = 6'd0;
    inData  = inBeat(0);
    @(negedge clk);
    inSop  = 1'b0;
    inData = inBeat(1);
    #1;
    checkOutput("midRst streaming", outValid, 1);
    rstN = 1'b0;
    #1;
    expPtr = 0;
    expDrop = 0;
    checkOutput("midRst outValid", outValid, 0);
    checkOutput("midRst nocDst", nocDst, 4);
    checkOutput("midRst dropCnt", dropCnt, 0);
    @(negedge clk);
    inValid = 1'b0;
    rstN = 1'b1;
    applyStimulus("postRst", 64, 16'h0800, 19, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
